// File: rtl/bip_uart_loader.sv
// bip_uart_loader: assembles UART bytes into little-endian words and writes them into BIP program memory
module bip_uart_loader #(
    parameter int DBIT      = 8,
    parameter int NBITS_O   = 11,
    parameter int NBITS_D   = 16,
    parameter int MAX_WORDS = 64,
    parameter int TIMEOUT   = 4096
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_rx_done,
    input  logic [DBIT-1:0]    i_rx_data,
    output logic               o_wr_en,
    output logic [NBITS_O-1:0] o_wr_addr,
    output logic [NBITS_D-1:0] o_wr_data,
    output logic               o_bip_reset,
    output logic               o_load_done,
    output logic               o_error
);
    localparam int CW = NBITS_O + 1;
    localparam logic [DBIT-1:0] MAXW = DBIT'(MAX_WORDS);
    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t state, state_n;
    logic [DBIT-1:0] n, n_n, low, low_n;
    logic [CW-1:0] idx, idx_n, idx_inc;
    logic [15:0] tcnt, tcnt_n;
    logic err_pend, pend_n;
    logic wr_en_n, bip_n, done_n, err_n;
    logic [NBITS_O-1:0] wr_addr_n;
    logic [NBITS_D-1:0] wr_data_n;
    logic count_ok;

    assign idx_inc  = idx + CW'(1);
    assign count_ok = (i_rx_data != '0) && (i_rx_data <= MAXW);

    // state, datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            n           <= '0;
            low         <= '0;
            idx         <= '0;
            tcnt        <= '0;
            err_pend    <= 1'b0;
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_bip_reset <= 1'b1;
            o_load_done <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            state       <= state_n;
            n           <= n_n;
            low         <= low_n;
            idx         <= idx_n;
            tcnt        <= tcnt_n;
            err_pend    <= pend_n;
            o_wr_en     <= wr_en_n;
            o_wr_addr   <= wr_addr_n;
            o_wr_data   <= wr_data_n;
            o_bip_reset <= bip_n;
            o_load_done <= done_n;
            o_error     <= err_n;
        end
    end

    // next state and next output values; a count byte rejected in DONE defers its error one cycle so it never coincides with load_done
    always_comb begin
        state_n   = state;
        n_n       = n;
        low_n     = low;
        idx_n     = idx;
        tcnt_n    = tcnt;
        pend_n    = 1'b0;
        wr_en_n   = 1'b0;
        wr_addr_n = o_wr_addr;
        wr_data_n = o_wr_data;
        bip_n     = o_bip_reset;
        done_n    = 1'b0;
        err_n     = err_pend;
        case (state)
            IDLE, DONE: begin
                tcnt_n = '0;
                if (state == DONE) begin
                    done_n  = 1'b1;
                    bip_n   = 1'b0;
                    state_n = IDLE;
                end
                if (i_rx_done) begin
                    if (count_ok) begin
                        n_n       = i_rx_data;
                        idx_n     = '0;
                        wr_addr_n = '0;
                        bip_n     = 1'b1;
                        state_n   = LOW;
                    end else if (state == DONE) begin
                        pend_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            default: begin
                if (i_rx_done) begin
                    tcnt_n = '0;
                    if (state == LOW) begin
                        low_n   = i_rx_data;
                        state_n = HIGH;
                    end else begin
                        wr_en_n   = 1'b1;
                        wr_data_n = {i_rx_data, low};
                        wr_addr_n = idx[NBITS_O-1:0];
                        idx_n     = idx_inc;
                        state_n   = (idx_inc == CW'(n)) ? DONE : LOW;
                    end
                end else if (i_s_tick) begin
                    tcnt_n  = (tcnt == TLAST) ? '0 : tcnt + 16'd1;
                    err_n   = (tcnt == TLAST) | err_pend;
                    state_n = (tcnt == TLAST) ? IDLE : state;
                end
            end
        endcase
    end
endmodule
